// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and instruction memory (slave); signal names match the original fetch ports.
interface if_fetch_unit_if;
    logic        proc2Imem_req;
    logic [31:0] proc2Imem_addr;
    logic        Imem2proc_gnt;
    logic        Imem2proc_valid;
    logic [31:0] Imem2proc_data;

    modport master (
        output proc2Imem_req,
        output proc2Imem_addr,
        input  Imem2proc_gnt,
        input  Imem2proc_valid,
        input  Imem2proc_data
    );

    modport slave (
        input  proc2Imem_req,
        input  proc2Imem_addr,
        output Imem2proc_gnt,
        output Imem2proc_valid,
        output Imem2proc_data
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: credit-limited in-order fetch into a small FIFO, redirect
// with in-flight response discard. Define IF_STALL_CNT_EN to add the decode-stall counter.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    if_fetch_unit_if.master       imem,
    input  logic                  ex_take_branch,
    input  logic [31:0]           ex_target_pc,
    input  logic                  id_ready,
    output logic                  if_valid,
    output logic [31:0]           if_inst,
    output logic [31:0]           if_pc,
    output logic [31:0]           if_npc
`ifdef IF_STALL_CNT_EN
    ,
    output logic [31:0]           if_stall_cycles
`endif
);

    localparam int unsigned PW      = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CW      = $clog2(BUF_DEPTH + 1);
    localparam logic [CW:0] L_DEPTH = (CW + 1)'(BUF_DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [31:0]   r_buf_inst [BUF_DEPTH];
    logic [31:0]   r_buf_pc   [BUF_DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop;

    logic          w_credit;
    logic          w_fire;
    logic          w_resp;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_target;

    // Credits cover both buffered and in-flight words, so a response always has a slot.
    always_comb begin
        w_credit            = ({1'b0, r_outstanding} + {1'b0, r_count}) < L_DEPTH;
        imem.proc2Imem_req  = !reset && !ex_take_branch && w_credit;
        imem.proc2Imem_addr = r_fetch_pc;
        w_fire              = imem.proc2Imem_req && imem.Imem2proc_gnt;
        w_resp              = imem.Imem2proc_valid;
        w_push              = w_resp && (r_drop == '0) && !ex_take_branch;
        w_target            = ex_target_pc & ~32'h0000_0003;
    end

    always_comb begin
        if_valid = (r_count != '0);
        if_inst  = if_valid ? r_buf_inst[r_rd_ptr] : NOP;
        if_pc    = if_valid ? r_buf_pc[r_rd_ptr] : 32'h0000_0000;
        if_npc   = if_pc + 32'd4;
        w_pop    = if_valid && id_ready;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop        <= '0;
        end else begin
            if (ex_take_branch) begin
                // Everything still in flight, minus a response landing now, belongs to the old path.
                r_fetch_pc <= w_target;
                r_resp_pc  <= w_target;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_count    <= '0;
                r_drop     <= r_outstanding - CW'(w_resp);
            end else begin
                if (w_fire)
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_resp && (r_drop != '0))
                    r_drop <= r_drop - CW'(1);
                if (w_push) begin
                    r_buf_inst[r_wr_ptr] <= imem.Imem2proc_data;
                    r_buf_pc[r_wr_ptr]   <= r_resp_pc;
                    r_wr_ptr             <= r_wr_ptr + PW'(1);
                    r_resp_pc            <= r_resp_pc + 32'd4;
                end
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: ;
                endcase
            end
            case ({w_fire, w_resp})
                2'b10:   r_outstanding <= r_outstanding + CW'(1);
                2'b01:   r_outstanding <= r_outstanding - CW'(1);
                default: ;
            endcase
        end
    end

`ifdef IF_STALL_CNT_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clock) begin
        if (reset)
            r_stall_cycles <= '0;
        else if (id_ready && !if_valid)
            r_stall_cycles <= r_stall_cycles + 32'd1;
    end

    assign if_stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with an in-order instruction memory model of
// configurable response latency; stall-counter scenario only when IF_STALL_CNT_EN is defined.
module tb_if_fetch_unit;

    localparam logic [31:0] P_RESET_PC = 32'h0000_0000;
    localparam int unsigned P_DEPTH    = 2;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ex_take_branch = 1'b0;
    logic [31:0] ex_target_pc = 32'h0;
    logic        id_ready = 1'b0;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic [31:0] if_npc;
`ifdef IF_STALL_CNT_EN
    logic [31:0] if_stall_cycles;
`endif

    if_fetch_unit_if imem ();

    if_fetch_unit #(
        .RESET_PC (P_RESET_PC),
        .BUF_DEPTH(P_DEPTH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .imem           (imem),
        .ex_take_branch (ex_take_branch),
        .ex_target_pc   (ex_target_pc),
        .id_ready       (id_ready),
        .if_valid       (if_valid),
        .if_inst        (if_inst),
        .if_pc          (if_pc),
        .if_npc         (if_npc)
`ifdef IF_STALL_CNT_EN
        ,
        .if_stall_cycles(if_stall_cycles)
`endif
    );

    typedef struct { logic [31:0] addr; int due; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; logic [31:0] npc; } ent_t;

    req_t mem_q[$];
    ent_t log_q[$];
    int   mem_cyc = 0;
    int   mem_lat = 1;
    int   n_checks = 0;
    int   n_pass = 0;

    function automatic logic [31:0] f_inst(input logic [31:0] a);
        return {a[31:2], 2'b11} ^ 32'hC3A5_0000;
    endfunction

    always #5 clock = ~clock;

    // Memory decides at the falling edge what the next rising edge will see.
    always @(negedge clock) begin
        mem_cyc++;
        if (mem_q.size() != 0 && mem_q[0].due <= mem_cyc) begin
            imem.Imem2proc_valid = 1'b1;
            imem.Imem2proc_data  = f_inst(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            imem.Imem2proc_valid = 1'b0;
            imem.Imem2proc_data  = 32'hDEAD_BEEF;
        end
        if (imem.proc2Imem_req && imem.Imem2proc_gnt)
            mem_q.push_back('{imem.proc2Imem_addr, mem_cyc + mem_lat});
        if (!reset && if_valid && id_ready)
            log_q.push_back('{if_pc, if_inst, if_npc});
    end

    initial begin
        #100000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ex_take_branch = 1'b0;
        mem_q.delete();
        tick();
        tick();
        log_q.delete();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        imem.Imem2proc_gnt = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        n_checks++; if (imem.proc2Imem_req !== 1'b0) $display("FAIL reset_req got %0b want 0", imem.proc2Imem_req); else n_pass++;
        n_checks++; if (if_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", if_valid); else n_pass++;
        n_checks++; if (if_inst !== NOP) $display("FAIL reset_inst got %h want %h", if_inst, NOP); else n_pass++;
        n_checks++; if (if_pc !== 32'h0) $display("FAIL reset_pc got %h want 0", if_pc); else n_pass++;
        n_checks++; if (if_npc !== 32'h4) $display("FAIL reset_npc got %h want 4", if_npc); else n_pass++;
`ifdef IF_STALL_CNT_EN
        n_checks++; if (if_stall_cycles !== 32'h0) $display("FAIL reset_stall got %0d want 0", if_stall_cycles); else n_pass++;
`endif
    endtask

    task automatic test_zero_wait();
        mem_lat = 1;
        id_ready = 1'b1;
        do_reset();
        n_checks++; if (imem.proc2Imem_addr !== P_RESET_PC) $display("FAIL zw_first_addr got %h want %h", imem.proc2Imem_addr, P_RESET_PC); else n_pass++;
        tick();
        n_checks++; if (if_valid !== 1'b0) $display("FAIL zw_c1_valid got %0b want 0", if_valid); else n_pass++;
        tick();
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0) $display("FAIL zw_c2 got v=%0b pc=%h want v=1 pc=0", if_valid, if_pc); else n_pass++;
        n_checks++; if (if_inst !== f_inst(32'h0) || if_npc !== 32'h4) $display("FAIL zw_c2_data got inst=%h npc=%h want %h 4", if_inst, if_npc, f_inst(32'h0)); else n_pass++;
        tick();
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_npc !== 32'h8) $display("FAIL zw_c3 got v=%0b pc=%h npc=%h want 1 4 8", if_valid, if_pc, if_npc); else n_pass++;
        for (int i = 0; i < 10; i++) tick();
        for (int i = 0; i < 5; i++) begin
            logic [31:0] epc;
            epc = 32'(i) * 32'd4;
            n_checks++;
            if (i >= log_q.size()) $display("FAIL zw_seq%0d got none want pc=%h", i, epc);
            else if (log_q[i].pc !== epc || log_q[i].inst !== f_inst(epc) || log_q[i].npc !== epc + 32'd4)
                $display("FAIL zw_seq%0d got pc=%h inst=%h npc=%h want pc=%h inst=%h npc=%h", i, log_q[i].pc, log_q[i].inst, log_q[i].npc, epc, f_inst(epc), epc + 32'd4);
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        mem_lat = 1;
        id_ready = 1'b0;
        do_reset();
        tick();
        for (int c = 2; c <= 5; c++) begin
            tick();
            n_checks++; if (imem.proc2Imem_req !== 1'b0) $display("FAIL stall_req_c%0d got %0b want 0", c, imem.proc2Imem_req); else n_pass++;
            if (c >= 3) begin
                n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_inst !== f_inst(32'h0))
                    $display("FAIL stall_hold_c%0d got v=%0b pc=%h inst=%h want 1 0 %h", c, if_valid, if_pc, if_inst, f_inst(32'h0)); else n_pass++;
            end
        end
        id_ready = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        for (int i = 0; i < 6; i++) begin
            logic [31:0] epc;
            epc = 32'(i) * 32'd4;
            n_checks++;
            if (i >= log_q.size()) $display("FAIL stall_seq%0d got none want pc=%h", i, epc);
            else if (log_q[i].pc !== epc || log_q[i].inst !== f_inst(epc))
                $display("FAIL stall_seq%0d got pc=%h inst=%h want pc=%h inst=%h", i, log_q[i].pc, log_q[i].inst, epc, f_inst(epc));
            else n_pass++;
        end
    endtask

    task automatic test_redirect_inflight();
        logic found;
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h100; exp_pc[1] = 32'h104; exp_pc[2] = 32'h108;
        mem_lat = 3;
        id_ready = 1'b1;
        do_reset();
        tick();
        tick();
        n_checks++; if (mem_q.size() != 2) $display("FAIL rd_inflight got %0d want 2", mem_q.size()); else n_pass++;
        ex_take_branch = 1'b1;
        ex_target_pc = 32'h0000_0103;
        #1;
        n_checks++; if (imem.proc2Imem_req !== 1'b0) $display("FAIL rd_req_during got %0b want 0", imem.proc2Imem_req); else n_pass++;
        tick();
        ex_take_branch = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (imem.proc2Imem_req === 1'b1) found = 1'b1;
            else tick();
        end
        n_checks++; if (!found || imem.proc2Imem_addr !== 32'h100) $display("FAIL rd_next_addr got found=%0b addr=%h want 1 00000100", found, imem.proc2Imem_addr); else n_pass++;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (if_valid === 1'b1) found = 1'b1;
            else tick();
        end
        n_checks++; if (!found || if_pc !== 32'h100 || if_inst !== f_inst(32'h100) || if_npc !== 32'h104)
            $display("FAIL rd_first_valid got v=%0b pc=%h inst=%h npc=%h want 1 100 %h 104", found, if_pc, if_inst, if_npc, f_inst(32'h100)); else n_pass++;
        for (int i = 0; i < 15; i++) tick();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (i >= log_q.size()) $display("FAIL rd_seq%0d got none want pc=%h", i, exp_pc[i]);
            else if (log_q[i].pc !== exp_pc[i] || log_q[i].inst !== f_inst(exp_pc[i]))
                $display("FAIL rd_seq%0d got pc=%h inst=%h want pc=%h", i, log_q[i].pc, log_q[i].inst, exp_pc[i]);
            else n_pass++;
        end
    endtask

    task automatic test_redirect_same_cycle();
        logic [31:0] exp_pc [4];
        exp_pc[0] = 32'h0; exp_pc[1] = 32'h200; exp_pc[2] = 32'h204; exp_pc[3] = 32'h208;
        mem_lat = 1;
        id_ready = 1'b1;
        do_reset();
        tick();
        tick();
        ex_take_branch = 1'b1;
        ex_target_pc = 32'h0000_0200;
        #1;
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0) $display("FAIL sc_pop got v=%0b pc=%h want 1 0", if_valid, if_pc); else n_pass++;
        n_checks++; if (imem.Imem2proc_valid !== 1'b1) $display("FAIL sc_resp_present got %0b want 1", imem.Imem2proc_valid); else n_pass++;
        tick();
        ex_take_branch = 1'b0;
        #1;
        n_checks++; if (if_valid !== 1'b0 || if_inst !== NOP) $display("FAIL sc_flushed got v=%0b inst=%h want 0 %h", if_valid, if_inst, NOP); else n_pass++;
        n_checks++; if (imem.proc2Imem_req !== 1'b1 || imem.proc2Imem_addr !== 32'h200) $display("FAIL sc_target_req got req=%0b addr=%h want 1 200", imem.proc2Imem_req, imem.proc2Imem_addr); else n_pass++;
        tick();
        tick();
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h200) $display("FAIL sc_target_valid got v=%0b pc=%h want 1 200", if_valid, if_pc); else n_pass++;
        for (int i = 0; i < 6; i++) tick();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= log_q.size()) $display("FAIL sc_seq%0d got none want pc=%h", i, exp_pc[i]);
            else if (log_q[i].pc !== exp_pc[i] || log_q[i].inst !== f_inst(exp_pc[i]))
                $display("FAIL sc_seq%0d got pc=%h inst=%h want pc=%h", i, log_q[i].pc, log_q[i].inst, exp_pc[i]);
            else n_pass++;
        end
    endtask

    task automatic test_wrap_and_reset();
        mem_lat = 1;
        id_ready = 1'b1;
        do_reset();
        ex_take_branch = 1'b1;
        ex_target_pc = 32'hFFFF_FFFF;
        tick();
        ex_take_branch = 1'b0;
        #1;
        n_checks++; if (imem.proc2Imem_req !== 1'b1 || imem.proc2Imem_addr !== 32'hFFFF_FFFC) $display("FAIL wr_addr_top got req=%0b addr=%h want 1 fffffffc", imem.proc2Imem_req, imem.proc2Imem_addr); else n_pass++;
        tick();
        n_checks++; if (imem.proc2Imem_req !== 1'b1 || imem.proc2Imem_addr !== 32'h0) $display("FAIL wr_addr_wrap got req=%0b addr=%h want 1 0", imem.proc2Imem_req, imem.proc2Imem_addr); else n_pass++;
        tick();
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC || if_npc !== 32'h0 || if_inst !== f_inst(32'hFFFF_FFFC))
            $display("FAIL wr_top_inst got v=%0b pc=%h npc=%h inst=%h want 1 fffffffc 0 %h", if_valid, if_pc, if_npc, if_inst, f_inst(32'hFFFF_FFFC)); else n_pass++;
        tick();
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_npc !== 32'h4) $display("FAIL wr_wrapped_inst got v=%0b pc=%h npc=%h want 1 0 4", if_valid, if_pc, if_npc); else n_pass++;
        tick();
        reset = 1'b1;
        mem_q.delete();
        #1;
        n_checks++; if (imem.proc2Imem_req !== 1'b0) $display("FAIL mr_req_in_reset got %0b want 0", imem.proc2Imem_req); else n_pass++;
        tick();
        n_checks++; if (if_valid !== 1'b0 || if_inst !== NOP) $display("FAIL mr_outputs got v=%0b inst=%h want 0 %h", if_valid, if_inst, NOP); else n_pass++;
        n_checks++; if (if_pc !== 32'h0 || if_npc !== 32'h4) $display("FAIL mr_pc got pc=%h npc=%h want 0 4", if_pc, if_npc); else n_pass++;
        reset = 1'b0;
        log_q.delete();
        #1;
        n_checks++; if (imem.proc2Imem_req !== 1'b1 || imem.proc2Imem_addr !== P_RESET_PC) $display("FAIL mr_restart_addr got req=%0b addr=%h want 1 %h", imem.proc2Imem_req, imem.proc2Imem_addr, P_RESET_PC); else n_pass++;
        tick();
        tick();
        n_checks++; if (if_valid !== 1'b1 || if_pc !== P_RESET_PC || if_inst !== f_inst(P_RESET_PC)) $display("FAIL mr_restart_inst got v=%0b pc=%h inst=%h want 1 %h", if_valid, if_pc, if_inst, P_RESET_PC); else n_pass++;
    endtask

`ifdef IF_STALL_CNT_EN
    task automatic test_stall_counter();
        mem_lat = 2;
        id_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 3; i++) tick();
        n_checks++; if (if_valid !== 1'b1 || if_stall_cycles !== 32'd3) $display("FAIL sc_cnt_rise got v=%0b cnt=%0d want 1 3", if_valid, if_stall_cycles); else n_pass++;
        tick();
        n_checks++; if (if_valid !== 1'b1 || if_stall_cycles !== 32'd3) $display("FAIL sc_cnt_hold got v=%0b cnt=%0d want 1 3", if_valid, if_stall_cycles); else n_pass++;
        tick();
        tick();
        n_checks++; if (if_stall_cycles !== 32'd4) $display("FAIL sc_cnt_bubble got %0d want 4", if_stall_cycles); else n_pass++;
    endtask
`endif

    initial begin
        imem.Imem2proc_gnt   = 1'b1;
        imem.Imem2proc_valid = 1'b0;
        imem.Imem2proc_data  = 32'h0;
        test_reset();
        test_zero_wait();
        test_stall();
        test_redirect_inflight();
        test_redirect_same_cycle();
        test_wrap_and_reset();
`ifdef IF_STALL_CNT_EN
        test_stall_counter();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
